// File: rtl/btl_pkg.sv
// Shared types and target arithmetic for the programmable branch-target LUT.
package btl_pkg;

    // Widest offset / PC the target arithmetic supports; callers narrow the result.
    localparam int unsigned BTL_W_MAX = 32;

    typedef enum logic [0:0] {
        BTL_INIT = 1'b0,
        BTL_RUN  = 1'b1
    } btl_state_e;

    // Entry as seen by the target adder. The owning module fills off already
    // extended to BTL_W_MAX: zero-extended when abs, sign-extended otherwise.
    typedef struct packed {
        logic                 valid;
        logic                 abs;
        logic [BTL_W_MAX-1:0] off;
    } btl_entry_t;

    // Branch target at full width; low PC bits are the modulo-2**PC_W result.
    function automatic logic [BTL_W_MAX-1:0] btl_target(
        input btl_entry_t           entry,
        input logic [BTL_W_MAX-1:0] pc,
        input logic [BTL_W_MAX-1:0] default_off
    );
        logic [BTL_W_MAX-1:0] res;
        if (!entry.valid) begin
            res = pc + default_off;
        end else if (entry.abs) begin
            res = entry.off;
        end else begin
            res = pc + entry.off;
        end
        return res;
    endfunction

endpackage

// File: rtl/btl_if.sv
// Loader, lookup and target handshakes of the branch-target LUT.
interface btl_if #(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned OFF_W = 10,
    parameter int unsigned PC_W  = 10
);
    logic             wr_en;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_idx;
    logic [OFF_W-1:0] wr_off;
    logic             wr_abs;

    logic             lk_valid;
    logic             lk_ready;
    logic [IDX_W-1:0] lk_idx;
    logic [PC_W-1:0]  lk_pc;

    logic             tgt_valid;
    logic             tgt_ready;
    logic [PC_W-1:0]  tgt_pc;
    logic             tgt_hit;

    // Decode / loader / PC-register side.
    modport master (
        output wr_en, wr_idx, wr_off, wr_abs,
        output lk_valid, lk_idx, lk_pc,
        output tgt_ready,
        input  wr_ready, lk_ready, tgt_valid, tgt_pc, tgt_hit
    );

    // LUT side.
    modport slave (
        input  wr_en, wr_idx, wr_off, wr_abs,
        input  lk_valid, lk_idx, lk_pc,
        input  tgt_ready,
        output wr_ready, lk_ready, tgt_valid, tgt_pc, tgt_hit
    );
endinterface

// File: rtl/btl_entry_ram.sv
// Entry storage: one write port, one asynchronous read port, per-entry valid clear.
module btl_entry_ram #(
    parameter int unsigned IDX_W = 8,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned OFF_W = 10
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_abs,
    input  logic [OFF_W-1:0] wr_off,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid_c,
    output logic             rd_abs_c,
    output logic [OFF_W-1:0] rd_off_c
);
    // Storage is deliberately not reset; the owner's INIT sweep clears valid bits.
    logic             valid_q [DEPTH];
    logic             abs_q   [DEPTH];
    logic [OFF_W-1:0] off_q   [DEPTH];

    // Clear wins over write; the owner never issues both in one cycle.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid_q[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            abs_q[wr_idx]   <= wr_abs;
            off_q[wr_idx]   <= wr_off;
        end
    end

    // Asynchronous read; caller keeps rd_idx in range.
    always_comb begin
        rd_valid_c = valid_q[rd_idx];
        rd_abs_c   = abs_q[rd_idx];
        rd_off_c   = off_q[rd_idx];
    end
endmodule

// File: rtl/branch_target_lut.sv
// Runtime-programmable branch-target LUT with registered target output.
module branch_target_lut
    import btl_pkg::*;
#(
    parameter int unsigned IDX_W       = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned OFF_W       = 10,
    parameter int unsigned PC_W        = 10,
    parameter int          DEFAULT_OFF = 1
) (
    input logic  clk,
    input logic  reset_n,
    input logic  flush,
    btl_if.slave bus
);
    localparam logic [0:0] S_INIT = BTL_INIT;
    localparam logic [0:0] S_RUN  = BTL_RUN;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             run;
    logic             clr_en;
    logic             wr_in_range, lk_in_range;
    logic             wr_fire, lk_fire, bypass;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid_c, rd_abs_c;
    logic [OFF_W-1:0] rd_off_c;
    logic             sel_valid, sel_abs;
    logic [OFF_W-1:0] sel_off;
    btl_entry_t       ent;
    logic [PC_W-1:0]  tgt_pc_d;
    logic             tgt_valid_q, tgt_hit_q;
    logic [PC_W-1:0]  tgt_pc_q;

    // Handshake qualifiers; flush overrides both ports.
    assign run          = (state_q == S_RUN);
    assign clr_en       = (state_q == S_INIT);
    assign wr_in_range  = (32'(bus.wr_idx) < DEPTH);
    assign lk_in_range  = (32'(bus.lk_idx) < DEPTH);
    assign wr_fire      = bus.wr_en && run && wr_in_range && !flush;
    assign lk_fire      = bus.lk_valid && bus.lk_ready && !flush;
    assign bypass       = wr_fire && (bus.wr_idx == bus.lk_idx);
    assign rd_idx       = lk_in_range ? bus.lk_idx : '0;

    assign bus.wr_ready  = run;
    assign bus.lk_ready  = run && (!tgt_valid_q || bus.tgt_ready);
    assign bus.tgt_valid = tgt_valid_q;
    assign bus.tgt_pc    = tgt_pc_q;
    assign bus.tgt_hit   = tgt_hit_q;

    btl_entry_ram #(
        .IDX_W (IDX_W),
        .DEPTH (DEPTH),
        .OFF_W (OFF_W)
    ) u_ram (
        .clk        (clk),
        .wr_en      (wr_fire),
        .wr_idx     (bus.wr_idx),
        .wr_abs     (bus.wr_abs),
        .wr_off     (bus.wr_off),
        .clr_en     (clr_en),
        .clr_idx    (clr_cnt_q),
        .rd_idx     (rd_idx),
        .rd_valid_c (rd_valid_c),
        .rd_abs_c   (rd_abs_c),
        .rd_off_c   (rd_off_c)
    );

    // State and clear-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // INIT sweeps one entry per cycle for DEPTH cycles; flush restarts the sweep.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (flush) begin
            state_d   = S_INIT;
            clr_cnt_d = '0;
        end else if (state_q == S_INIT) begin
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d   = S_RUN;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
            end
        end
    end

    // Write-through bypass, entry widening and target arithmetic.
    always_comb begin
        sel_valid = rd_valid_c;
        sel_abs   = rd_abs_c;
        sel_off   = rd_off_c;
        if (bypass) begin
            sel_valid = 1'b1;
            sel_abs   = bus.wr_abs;
            sel_off   = bus.wr_off;
        end
        ent.valid = sel_valid && lk_in_range;
        ent.abs   = sel_abs;
        ent.off   = sel_abs ? BTL_W_MAX'(sel_off) : BTL_W_MAX'($signed(sel_off));
        tgt_pc_d  = PC_W'(btl_target(ent, BTL_W_MAX'(bus.lk_pc), BTL_W_MAX'(DEFAULT_OFF)));
    end

    // Target register: flush drops it, fire loads it, accept without fire empties it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt_valid_q <= 1'b0;
            tgt_pc_q    <= '0;
            tgt_hit_q   <= 1'b0;
        end else if (flush) begin
            tgt_valid_q <= 1'b0;
        end else if (lk_fire) begin
            tgt_valid_q <= 1'b1;
            tgt_pc_q    <= tgt_pc_d;
            tgt_hit_q   <= ent.valid;
        end else if (bus.tgt_ready) begin
            tgt_valid_q <= 1'b0;
        end
    end

    // Remembers whether the previous cycle was a stall, for the hold check.
    logic            hold_q;
    logic [PC_W-1:0] hold_pc_q;
    logic            hold_hit_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q     <= 1'b0;
            hold_pc_q  <= '0;
            hold_hit_q <= 1'b0;
        end else begin
            hold_q     <= tgt_valid_q && !bus.tgt_ready;
            hold_pc_q  <= tgt_pc_q;
            hold_hit_q <= tgt_hit_q;
        end
    end

    // Parameter sanity and target stability across a stall.
    always_ff @(posedge clk) begin
        assert (DEPTH >= 1 && DEPTH <= (2 ** IDX_W))
            else $error("DEPTH out of range for IDX_W");
        assert (OFF_W <= BTL_W_MAX && PC_W <= BTL_W_MAX)
            else $error("OFF_W/PC_W wider than supported");
        if (reset_n && hold_q) begin
            assert (tgt_pc_q == hold_pc_q && tgt_hit_q == hold_hit_q)
                else $error("target changed while stalled");
        end
    end
endmodule
